system_keys_in: RTL and testbench



---
 rtl/system_keys_in.sv | 125 ++++++++++++
 tb/tb_system_keys_in.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/system_keys_in.sv
// Avalon-MM input PIO for the key/switch bank: two-flop synchronizer, ticked
// per-bit debounce, edge capture with write-1-to-clear, and a masked level irq.
module system_keys_in #(
  parameter int              WIDTH        = 4,
  parameter int              TICK_DIV     = 50000,
  parameter int              STABLE_TICKS = 4,
  parameter int              EDGE_TYPE    = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Bus handshake: a write is taken on every clk edge where chipselect=1 and
  // write_n=0; reads are zero-wait, combinational and free of side effects.

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] deb, deb_prev;
  logic [WIDTH-1:0] irqmask, edgecapture;
  logic [WIDTH-1:0] edge_evt, clr_bits;
  logic [PW-1:0]    pcnt;
  logic [CW-1:0]    cnt [WIDTH];
  logic             tick;
  logic             wr;

  assign wr   = chipselect && !write_n;
  assign tick = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  // Any cycle agreeing with the debounced level restarts that bit's count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= RESET_VALUE;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CW'(STABLE_TICKS - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // deb_prev resets with deb so reset itself never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) deb_prev <= RESET_VALUE;
    else          deb_prev <= deb;
  end

  always_comb begin
    edge_evt = '0;
    clr_bits = '0;
    case (EDGE_TYPE)
      0:       edge_evt = deb & ~deb_prev;
      1:       edge_evt = ~deb & deb_prev;
      default: edge_evt = deb ^ deb_prev;
    endcase
    if (wr && address == 2'd3) clr_bits = writedata[WIDTH-1:0];
  end

  // Set is OR-ed after the clear so a same-cycle event wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr_bits) | edge_evt;
    end
  end

  assign irq = |(edgecapture & irqmask);

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata[WIDTH-1:0] = deb;
        2'd2:    readdata[WIDTH-1:0] = irqmask;
        2'd3:    readdata[WIDTH-1:0] = edgecapture;
        default: readdata = '0;
      endcase
    end
  end

  generate
    if (WIDTH < 32) begin : g_wd_unused
      logic unused_writedata;
      assign unused_writedata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_system_keys_in.sv
// Bench for system_keys_in: WIDTH=4, TICK_DIV=4, STABLE_TICKS=3, falling-edge capture.
module tb_system_keys_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  system_keys_in #(
    .WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3), .EDGE_TYPE(1), .RESET_VALUE(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drivers: every step lands 1ns after the rising edge with the bus idle
  task automatic step();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_val(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    address    = a;
    #1;
    d = readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    exp_q.push_back(exp);
    read_val(a, d);
    check(tag, d, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
  endtask

  // Returns the number of edges until offset 0 shows target, or 999.
  task automatic wait_data(input logic [3:0] target, output int n);
    logic [31:0] d;
    n = 999;
    for (int c = 1; c <= 40; c++) begin
      step();
      read_val(2'd0, d);
      if (d[3:0] == target) begin
        n = c;
        break;
      end
    end
  endtask

  // 2 sync edges plus 9..12 edges of tick-phase dependent debounce
  task automatic chk_lat(input string tag, input int n);
    $display("info %s latency=%0d", tag, n);
    check(tag, 32'((n >= 11 && n <= 14) ? 1 : 0), 32'd1);
  endtask

  initial begin
    int n;
    int lo, hi;
    logic [31:0] d;
    logic got_cap;

    reset_n    = 1'b0;
    in_port    = 4'hF;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset state
    rd_chk("rst_data", 2'd0, 32'hF);
    rd_chk("rst_rsvd", 2'd1, 32'h0);
    rd_chk("rst_mask", 2'd2, 32'h0);
    rd_chk("rst_ecap", 2'd3, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    repeat (10) step();
    check("rst_irq_idle", {31'd0, irq}, 32'd0);
    rd_chk("rst_ecap_idle", 2'd3, 32'h0);

    // clean press of bit 0
    in_port = 4'hE;
    wait_data(4'hE, n);
    chk_lat("press0_lat", n);
    rd_chk("press0_ecap_early", 2'd3, 32'h0);
    step();
    rd_chk("press0_ecap", 2'd3, 32'h1);
    check("press0_irq", {31'd0, irq}, 32'd0);

    // release is a rising edge: no new capture, then clear
    in_port = 4'hF;
    wait_data(4'hF, n);
    chk_lat("rel0_lat", n);
    step();
    rd_chk("rel0_ecap", 2'd3, 32'h1);
    wr(2'd3, 32'hF);
    rd_chk("w1c_all", 2'd3, 32'h0);

    // bounce on bit 1: no run is long enough to qualify
    for (int k = 0; k < 5; k++) begin
      lo = $urandom_range(1, 6);
      hi = $urandom_range(1, 6);
      in_port = 4'hD;
      repeat (lo) step();
      in_port = 4'hF;
      repeat (hi) step();
    end
    repeat (20) step();
    rd_chk("bounce_data", 2'd0, 32'hF);
    rd_chk("bounce_ecap", 2'd3, 32'h0);
    in_port = 4'hD;
    repeat (20) step();
    rd_chk("hold1_data", 2'd0, 32'hD);
    rd_chk("hold1_ecap", 2'd3, 32'h2);

    // interrupt path on bit 1
    in_port = 4'hF;
    repeat (20) step();
    wr(2'd3, 32'hF);
    rd_chk("irq_pre_ecap", 2'd3, 32'h0);
    wr(2'd2, 32'h2);
    rd_chk("irq_mask_rd", 2'd2, 32'h2);
    check("irq_pre", {31'd0, irq}, 32'd0);
    in_port = 4'hD;
    got_cap = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      read_val(2'd3, d);
      if (d != 32'd0) begin
        check("irq_cap_ecap", d, 32'h2);
        check("irq_with_cap", {31'd0, irq}, 32'd1);
        got_cap = 1'b1;
        break;
      end
      check("irq_before_cap", {31'd0, irq}, 32'd0);
    end
    check("irq_cap_seen", {31'd0, got_cap}, 32'd1);
    wr(2'd3, 32'h2);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd_chk("ecap_after_w1c", 2'd3, 32'h0);
    in_port = 4'hF;
    repeat (20) step();
    rd_chk("rel1_ecap", 2'd3, 32'h0);
    check("rel1_irq", {31'd0, irq}, 32'd0);

    // set/clear collision on bit 0: W1C in the very cycle the event sets it
    in_port = 4'hE;
    wait_data(4'hE, n);
    chk_lat("coll_lat", n);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd3;
    writedata  = 32'h1;
    step();
    rd_chk("coll_ecap", 2'd3, 32'h1);
    check("coll_irq_masked", {31'd0, irq}, 32'd0);

    // unmasking an already-pending bit raises irq the cycle after the write
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd2;
    writedata  = 32'h1;
    #1 check("mask_irq_during", {31'd0, irq}, 32'd0);
    step();
    check("mask_irq_after", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h1);
    check("mask_irq_w1c", {31'd0, irq}, 32'd0);
    in_port = 4'hF;
    repeat (20) step();
    wr(2'd2, 32'h0);
    rd_chk("rel0b_ecap", 2'd3, 32'h0);

    // writes to offsets 0 and 1 are ignored
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0);
    rd_chk("ign_data", 2'd0, 32'hF);
    rd_chk("ign_rsvd", 2'd1, 32'h0);
    rd_chk("ign_mask", 2'd2, 32'h0);

    // reset mid-debounce abandons the pending press of bit 2
    in_port = 4'hB;
    repeat (8) step();
    rd_chk("mid_data", 2'd0, 32'hF);
    reset_n = 1'b0;
    in_port = 4'hF;
    step();
    step();
    reset_n = 1'b1;
    rd_chk("mid_rst_data", 2'd0, 32'hF);
    rd_chk("mid_rst_ecap", 2'd3, 32'h0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    repeat (3) step();
    in_port = 4'hB;
    wait_data(4'hB, n);
    chk_lat("repress_lat", n);
    step();
    rd_chk("repress_ecap", 2'd3, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
